// File: rtl/ysyx_22041412_csr_pkg.sv
// Shared definitions for the EXU-side machine-CSR request controller.
//   - CSR numbers of the supported machine CSRs
//   - 3-bit unit index encodings understood by the CSR unit
//   - request kind / response error / controller state enums
package ysyx_22041412_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] IDX_MRET    = 3'd0;
  localparam logic [2:0] IDX_ECALL   = 3'd1;
  localparam logic [2:0] IDX_MSTATUS = 3'd2;
  localparam logic [2:0] IDX_MTVEC   = 3'd3;
  localparam logic [2:0] IDX_MEPC    = 3'd4;
  localparam logic [2:0] IDX_MCAUSE  = 3'd5;

  typedef enum logic [1:0] {
    KIND_CSR   = 2'd0,
    KIND_ECALL = 2'd1,
    KIND_MRET  = 2'd2,
    KIND_RSVD  = 2'd3
  } req_kind_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } rsp_err_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACK,
    S_DRAIN,
    S_RESP
  } state_e;

  // func3 low bits 00 (000 / 100) are not CSR read-modify-write encodings.
  function automatic logic func3_is_csr_op(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22041412_csr_decode.sv
// Combinational decode of a CSR-class instruction into CSR unit controls.
//   csr_num   : inst[31:20] CSR number
//   kind      : CSR op / ecall / mret / reserved
//   func3_in  : inst[14:12]
//   addr      : 3-bit unit index
//   func3_out : func3 presented to the unit (000 for ecall/mret)
//   illegal   : request must complete with an illegal error, no unit access
module ysyx_22041412_csr_decode
  import ysyx_22041412_csr_pkg::*;
(
  input  logic [11:0] csr_num,
  input  req_kind_e   kind,
  input  logic [2:0]  func3_in,
  output logic [2:0]  addr,
  output logic [2:0]  func3_out,
  output logic        illegal
);

  logic       mapped;
  logic [2:0] csr_idx;

  always_comb begin
    mapped  = 1'b1;
    csr_idx = IDX_MRET;
    case (csr_num)
      CSR_MSTATUS: csr_idx = IDX_MSTATUS;
      CSR_MTVEC:   csr_idx = IDX_MTVEC;
      CSR_MEPC:    csr_idx = IDX_MEPC;
      CSR_MCAUSE:  csr_idx = IDX_MCAUSE;
      default:     mapped  = 1'b0;
    endcase
  end

  always_comb begin
    addr      = '0;
    func3_out = '0;
    illegal   = 1'b0;
    case (kind)
      KIND_CSR: begin
        addr      = csr_idx;
        func3_out = func3_in;
        illegal   = !mapped || !func3_is_csr_op(func3_in);
      end
      KIND_ECALL: addr = IDX_ECALL;
      KIND_MRET:  addr = IDX_MRET;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_22041412_csr_req.sv
// EXU-side initiator for the machine-CSR unit handshake.
// Accepts one CSR-class instruction while idle, drives the unit through
// REQ (wait for ready) -> ACK (one-cycle valid_i) -> DRAIN (wait for ready
// to fall) and then holds the result for WBU until rsp_valid && rsp_ready.
//   req_*           : decoded instruction in, req_ready = idle
//   csr_*           : unit interface (en/addr/func3/data_i/pc/valid_i out,
//                     ready_o/data_o in)
//   rsp_*           : old CSR value, PC redirect and error status to WBU
//   busy            : pipeline stall, high in any state but IDLE
module ysyx_22041412_csr_req
  import ysyx_22041412_csr_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned XLEN    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [2:0]      req_func3,
  input  logic [11:0]     req_csr,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [4:0]      req_zimm,
  input  logic [XLEN-1:0] req_pc,
  output logic            csr_en,
  output logic [2:0]      csr_addr,
  output logic [2:0]      csr_func3,
  output logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_pc,
  output logic            csr_valid_i,
  input  logic            csr_ready_o,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rd_data,
  output logic            rsp_redirect,
  output logic [XLEN-1:0] rsp_redirect_pc,
  output logic [1:0]      rsp_err,
  output logic            busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  req_kind_e       kind_q, kind_d;
  logic [2:0]      addr_q, addr_d;
  logic [2:0]      func3_q, func3_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  rsp_err_e        err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  req_kind_e       req_kind_w;
  logic [2:0]      dec_addr;
  logic [2:0]      dec_func3;
  logic            dec_illegal;
  logic [XLEN-1:0] req_operand;
  logic            rsp_ok;

  assign req_kind_w  = req_kind_e'(req_kind);
  assign req_operand = req_func3[2] ? {{(XLEN-5){1'b0}}, req_zimm} : req_rs1;

  ysyx_22041412_csr_decode u_decode (
    .csr_num   (req_csr),
    .kind      (req_kind_w),
    .func3_in  (req_func3),
    .addr      (dec_addr),
    .func3_out (dec_func3),
    .illegal   (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    func3_d = func3_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          kind_d  = req_kind_w;
          addr_d  = dec_addr;
          func3_d = dec_func3;
          wdata_d = req_operand;
          pc_d    = req_pc;
          rdata_d = '0;
          cnt_d   = '0;
          if (dec_illegal) begin
            err_d   = ERR_ILLEGAL;
            state_d = S_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A ready seen in the final counted cycle still wins over the timeout.
        if (csr_ready_o) begin
          rdata_d = csr_rdata;
          state_d = S_ACK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK:   state_d = S_DRAIN;
      S_DRAIN: if (!csr_ready_o) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      kind_q  <= KIND_CSR;
      addr_q  <= '0;
      func3_q <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      func3_q <= func3_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign csr_en      = (state_q == S_REQ) || (state_q == S_ACK);
  assign csr_valid_i = (state_q == S_ACK);
  assign csr_addr    = addr_q;
  assign csr_func3   = func3_q;
  assign csr_wdata   = wdata_q;
  assign csr_pc      = pc_q;

  // Result fields are only meaningful in RESP; elsewhere they read as zero.
  assign rsp_valid       = (state_q == S_RESP);
  assign rsp_ok          = rsp_valid && (err_q == ERR_OK);
  assign rsp_redirect    = rsp_ok && ((kind_q == KIND_ECALL) || (kind_q == KIND_MRET));
  assign rsp_rd_data     = (rsp_ok && (kind_q == KIND_CSR)) ? rdata_q : '0;
  assign rsp_redirect_pc = rsp_redirect ? rdata_q : '0;
  assign rsp_err         = rsp_valid ? err_q : ERR_OK;

endmodule

// File: tb/tb_ysyx_22041412_csr_req.sv
module tb_ysyx_22041412_csr_req;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = '0;
  logic [2:0]  req_func3 = '0;
  logic [11:0] req_csr = '0;
  logic [63:0] req_rs1 = '0;
  logic [4:0]  req_zimm = '0;
  logic [63:0] req_pc = '0;
  logic        csr_en;
  logic [2:0]  csr_addr;
  logic [2:0]  csr_func3;
  logic [63:0] csr_wdata;
  logic [63:0] csr_pc;
  logic        csr_valid_i;
  logic        csr_ready_o;
  logic [63:0] csr_rdata;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rd_data;
  logic        rsp_redirect;
  logic [63:0] rsp_redirect_pc;
  logic [1:0]  rsp_err;
  logic        busy;

  ysyx_22041412_csr_req #(.TIMEOUT(TIMEOUT), .XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_func3(req_func3), .req_csr(req_csr), .req_rs1(req_rs1),
    .req_zimm(req_zimm), .req_pc(req_pc),
    .csr_en(csr_en), .csr_addr(csr_addr), .csr_func3(csr_func3),
    .csr_wdata(csr_wdata), .csr_pc(csr_pc), .csr_valid_i(csr_valid_i),
    .csr_ready_o(csr_ready_o), .csr_rdata(csr_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_data(rsp_rd_data),
    .rsp_redirect(rsp_redirect), .rsp_redirect_pc(rsp_redirect_pc),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- CSR unit model ----------------
  // Raises ready u_delay cycles after en is first seen (0 = same cycle),
  // applies the write on the valid_i cycle, keeps ready up u_linger more cycles.
  logic [63:0] seed   [8];
  logic [63:0] u_regs [8];
  logic        u_seeded = 1'b0;
  logic        u_done;
  int          u_cnt, u_lin;
  int          u_delay = 0;
  int          u_linger = 0;

  function automatic int rd_idx(input logic [2:0] a);
    return (a == 3'd0) ? 4 : (a == 3'd1) ? 3 : int'(a);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_cnt  <= 0;
      u_lin  <= 0;
      u_done <= 1'b0;
      if (!u_seeded) begin
        for (int i = 0; i < 8; i++) u_regs[i] <= seed[i];
        u_seeded <= 1'b1;
      end
    end else begin
      if (u_lin > 0) u_lin <= u_lin - 1;
      if (csr_en && csr_valid_i) begin
        u_done <= 1'b1;
        u_lin  <= u_linger;
        if (csr_addr >= 3'd2 && csr_addr <= 3'd5) begin
          case (csr_func3[1:0])
            2'b01:   u_regs[csr_addr] <= csr_wdata;
            2'b10:   u_regs[csr_addr] <= u_regs[csr_addr] | csr_wdata;
            2'b11:   u_regs[csr_addr] <= u_regs[csr_addr] & ~csr_wdata;
            default: ;
          endcase
        end
      end else if (csr_en) begin
        if (!csr_ready_o) u_cnt <= u_cnt + 1;
      end else begin
        u_cnt  <= 0;
        u_done <= 1'b0;
      end
    end
  end

  assign csr_ready_o = (csr_en && !u_done && u_delay != NEVER && u_cnt >= u_delay) || (u_lin != 0);
  assign csr_rdata   = csr_ready_o ? u_regs[rd_idx(csr_addr)] : 64'hdead_beef_0bad_f00d;

  // ---------------- reference model ----------------
  logic [63:0] ref_csr [8];

  function automatic int spec_index(input logic [11:0] n);
    case (n)
      12'h300: return 2;
      12'h305: return 3;
      12'h341: return 4;
      12'h342: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic check_reset_outputs(input string pre);
    chk({pre, "_csr_en"}, 64'(csr_en), 0);
    chk({pre, "_valid_i"}, 64'(csr_valid_i), 0);
    chk({pre, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({pre, "_redirect"}, 64'(rsp_redirect), 0);
    chk({pre, "_busy"}, 64'(busy), 0);
    chk({pre, "_req_ready"}, 64'(req_ready), 1);
    chk({pre, "_addr"}, 64'(csr_addr), 0);
    chk({pre, "_func3"}, 64'(csr_func3), 0);
    chk({pre, "_wdata"}, csr_wdata, 0);
    chk({pre, "_pc"}, csr_pc, 0);
    chk({pre, "_rd_data"}, rsp_rd_data, 0);
    chk({pre, "_redir_pc"}, rsp_redirect_pc, 0);
    chk({pre, "_err"}, 64'(rsp_err), 0);
  endtask

  task automatic run_txn(input int kind, input logic [2:0] f3, input logic [11:0] csr,
                         input logic [63:0] rs1, input logic [4:0] zimm, input logic [63:0] pc,
                         input int delay, input int linger, input int hold, input bit junk);
    int          idx, e_err, e_lat, e_en, lat, en_cyc, vld_cyc;
    bit          illegal, tmo, e_redir, got;
    logic [2:0]  e_addr, e_f3;
    logic [63:0] w, old, e_rd, e_rpc;
    idx     = spec_index(csr);
    illegal = (kind == 3) || (kind == 0 && (idx < 0 || f3 == 3'b000 || f3 == 3'b100));
    w       = f3[2] ? 64'(zimm) : rs1;
    e_addr  = (kind == 1) ? 3'd1 : (kind == 2) ? 3'd0 : 3'(idx);
    e_f3    = (kind == 0) ? f3 : 3'b000;
    tmo     = !illegal && (delay == NEVER || delay >= TIMEOUT);
    e_err   = illegal ? 1 : tmo ? 2 : 0;
    e_lat   = illegal ? 1 : tmo ? TIMEOUT + 1 : delay + 4 + linger;
    e_en    = illegal ? 0 : tmo ? TIMEOUT : delay + 2;
    old     = (kind == 1) ? ref_csr[3] : (kind == 2) ? ref_csr[4] : (idx >= 0) ? ref_csr[idx] : 64'd0;
    e_redir = (e_err == 0) && (kind == 1 || kind == 2);
    e_rd    = (e_err == 0 && kind == 0) ? old : 64'd0;
    e_rpc   = e_redir ? old : 64'd0;

    u_delay  = delay;
    u_linger = linger;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 1);
    req_valid = 1'b1;
    req_kind  = 2'(kind);
    req_func3 = f3;
    req_csr   = csr;
    req_rs1   = rs1;
    req_zimm  = zimm;
    req_pc    = pc;
    en_cyc = 0; vld_cyc = 0; got = 1'b0; lat = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (csr_en) begin
        en_cyc++;
        chk("csr_addr", 64'(csr_addr), 64'(e_addr));
        chk("csr_func3", 64'(csr_func3), 64'(e_f3));
        chk("csr_wdata", csr_wdata, w);
        chk("csr_pc", csr_pc, pc);
      end
      if (csr_valid_i) begin
        vld_cyc++;
        chk("valid_needs_en", 64'(csr_en), 1);
      end
      if (rsp_valid) begin
        got = 1'b1;
        lat = c;
      end else if (junk) begin
        req_valid = 1'b1;
        req_kind  = 2'($urandom);
        req_func3 = 3'($urandom);
        req_csr   = 12'($urandom);
        req_rs1   = {$urandom, $urandom};
        req_zimm  = 5'($urandom);
        req_pc    = {$urandom, $urandom};
      end
    end
    chk("rsp_seen", 64'(got), 1);
    if (!got) begin
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    chk("latency", 64'(lat), 64'(e_lat));
    chk("en_cycles", 64'(en_cyc), 64'(e_en));
    chk("valid_pulses", 64'(vld_cyc), (illegal || tmo) ? 64'd0 : 64'd1);
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", 64'(rsp_valid), 1);
      chk("rsp_err", 64'(rsp_err), 64'(e_err));
      chk("rsp_rd_data", rsp_rd_data, e_rd);
      chk("rsp_redirect", 64'(rsp_redirect), 64'(e_redir));
      chk("rsp_redirect_pc", rsp_redirect_pc, e_rpc);
      chk("busy_resp", 64'(busy), 1);
      chk("req_ready_resp", 64'(req_ready), 0);
      chk("csr_en_resp", 64'(csr_en), 0);
      if (h == hold) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("rsp_valid_after", 64'(rsp_valid), 0);
    chk("busy_after", 64'(busy), 0);
    chk("req_ready_after", 64'(req_ready), 1);
    if (e_err == 0 && kind == 0) begin
      case (f3[1:0])
        2'b01:   ref_csr[idx] = w;
        2'b10:   ref_csr[idx] = ref_csr[idx] | w;
        2'b11:   ref_csr[idx] = ref_csr[idx] & ~w;
        default: ;
      endcase
    end
  endtask

  task automatic reset_mid();
    int vld;
    vld = 0;
    u_delay  = NEVER;
    u_linger = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_kind  = 2'd0;
    req_func3 = 3'b001;
    req_csr   = 12'h341;
    req_rs1   = 64'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_busy", 64'(busy), 1);
    chk("mid_en", 64'(csr_en), 1);
    repeat (3) begin
      @(negedge clk);
      if (csr_valid_i) vld++;
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if (csr_valid_i) vld++;
    chk("mid_busy_after", 64'(busy), 0);
    chk("mid_en_after", 64'(csr_en), 0);
    chk("mid_req_ready_after", 64'(req_ready), 1);
    chk("mid_no_valid", 64'(vld), 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) seed[i] = {$urandom, $urandom};
    seed[2] = 64'ha_0000_1800;
    seed[3] = 64'h0;
    seed[4] = 64'h8000_0044;
    for (int i = 0; i < 8; i++) ref_csr[i] = seed[i];

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;

    // CSRRW mtvec, immediate unit response
    run_txn(0, 3'b001, 12'h305, 64'h8000_0100, 5'd0, 64'h8000_0000, 0, 0, 0, 1'b0);
    // CSRRSI mstatus, zimm=8
    run_txn(0, 3'b110, 12'h300, 64'hffff, 5'd8, 64'h8000_0004, 0, 0, 0, 1'b0);
    // ecall
    run_txn(1, 3'b000, 12'h000, 64'h0, 5'd0, 64'h8000_0040, 0, 0, 0, 1'b0);
    // illegal: unmapped CSR, func3=100, reserved kind
    run_txn(0, 3'b001, 12'h7c0, 64'h5, 5'd0, 64'h8000_0008, 0, 0, 0, 1'b0);
    run_txn(0, 3'b100, 12'h300, 64'h5, 5'd0, 64'h8000_000c, 0, 0, 0, 1'b0);
    run_txn(3, 3'b001, 12'h300, 64'h5, 5'd0, 64'h8000_0010, 0, 0, 0, 1'b0);
    // unit never ready, then ready in the last / first-too-late REQ cycle
    run_txn(0, 3'b010, 12'h342, 64'h3, 5'd0, 64'h8000_0014, NEVER, 0, 0, 1'b0);
    run_txn(0, 3'b010, 12'h342, 64'h3, 5'd0, 64'h8000_0018, TIMEOUT - 1, 0, 0, 1'b0);
    run_txn(0, 3'b010, 12'h342, 64'h3, 5'd0, 64'h8000_001c, TIMEOUT, 0, 0, 1'b0);
    // ready lingering after ACK keeps DRAIN waiting
    run_txn(0, 3'b011, 12'h300, 64'h800, 5'd0, 64'h8000_0020, 2, 3, 1, 1'b1);
    // mret with WBU back-pressure, then reset mid-REQ
    run_txn(2, 3'b000, 12'h000, 64'h0, 5'd0, 64'h8000_0024, 1, 0, 5, 1'b0);
    reset_mid();

    for (int t = 0; t < 40; t++) begin
      int          r, k, d;
      logic [11:0] c;
      r = int'($urandom_range(0, 9));
      k = (r < 7) ? 0 : (r == 7) ? 1 : (r == 8) ? 2 : 3;
      case ($urandom_range(0, 4))
        0:       c = 12'h300;
        1:       c = 12'h305;
        2:       c = 12'h341;
        3:       c = 12'h342;
        default: c = 12'($urandom);
      endcase
      d = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 17));
      run_txn(k, 3'($urandom), c, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
              d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_csr_req.md
Name: ysyx_22041412_csr_req

Overview:
- Initiator side of the machine-CSR unit handshake (en / addr / func3 / data_i / data_o, valid_i / ready_o).
- Sits in the EXU. Accepts one decoded CSR-class instruction (CSRRx / CSRRxI / ecall / mret) and maps the CSR number to the unit's 3-bit index.
- Sequences the request/ack handshake, then returns the old CSR value for rd plus any PC redirect to WBU over a valid/ready pair.
- Stalls the pipeline while busy and flags illegal CSR numbers and unit timeouts.

Parameters:
- TIMEOUT, 16, maximum cycles waiting for csr_ready_o before an error completion.
- XLEN, 64, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  decoded CSR-class instruction present.
- req_ready  out  1  controller idle; accepts request.
- req_kind  in  2  0=CSR op, 1=ecall, 2=mret, 3=reserved (treated as illegal).
- req_func3  in  3  inst[14:12].
- req_csr  in  12  inst[31:20].
- req_rs1  in  XLEN  rs1 value.
- req_zimm  in  5  inst[19:15].
- req_pc  in  XLEN  instruction PC.
- csr_en  out  1  to unit en.
- csr_addr  out  3  to unit addr.
- csr_func3  out  3  to unit func3.
- csr_wdata  out  XLEN  to unit data_i.
- csr_pc  out  XLEN  to unit pc.
- csr_valid_i  out  1  ack to unit (drives its valid_i).
- csr_ready_o  in  1  from unit ready_o.
- csr_rdata  in  XLEN  from unit data_o.
- rsp_valid  out  1  result ready for WBU.
- rsp_ready  in  1  WBU accepts.
- rsp_rd_data  out  XLEN  old CSR value (0 for ecall/mret).
- rsp_redirect  out  1  PC redirect required.
- rsp_redirect_pc  out  XLEN  target (mtvec for ecall, mepc for mret).
- rsp_err  out  2  0=ok, 1=illegal CSR/kind, 2=timeout.
- busy  out  1  high in any state but IDLE; drives pipeline stall.

Behaviour:
- Reset (rst low, async): state=IDLE. csr_en, csr_valid_i, rsp_valid, rsp_redirect, busy all 0. All data outputs 0, rsp_err=0, timeout counter 0.
- CSR index map: 0x300→2 (mstatus), 0x305→3 (mtvec), 0x341→4 (mepc), 0x342→5 (mcause). Any other number is illegal.
- Index mapping for non-CSR kinds: ecall→addr 1, func3 000; mret→addr 0, func3 000.
- Illegal request conditions, each going straight to RESP with rsp_err=1, no csr_en pulse, rd_data=0:
  - CSR op with func3=000 or 100.
  - Unmapped CSR number.
  - req_kind=3.
- Write operand: func3[2]=1 → zero-extended zimm; func3[2]=0 → rs1. csr_wdata is registered at accept.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request; go to REQ, or to RESP if illegal.
- REQ:
  - csr_en=1, csr_valid_i=0; addr/func3/wdata/pc held stable.
  - Count cycles. If csr_ready_o=1, capture csr_rdata and go to ACK.
  - If the count reaches TIMEOUT with no ready: drop csr_en, go to RESP with rsp_err=2.
- ACK (exactly one cycle):
  - csr_en=1, csr_valid_i=1. The unit performs its write here and clears ready_o on the next edge.
  - Go to DRAIN.
- DRAIN:
  - csr_en=0, csr_valid_i=0.
  - Wait until csr_ready_o=0, then go to RESP. This prevents a back-to-back request from seeing a stale ready.
- RESP:
  - rsp_valid=1; outputs stable until rsp_valid && rsp_ready.
  - Result mapping: CSR op → rd_data=captured value, redirect=0. ecall → redirect=1, pc=captured value (mtvec), rd_data=0. mret → redirect=1, pc=captured value (mepc), rd_data=0.
  - On handshake go to IDLE; a new request is accepted no earlier than the following cycle.
- Minimum latency for a legal op with an immediate unit response: accept at T0; REQ T1; ready seen T2; ACK T2–T3; DRAIN T3; RESP T4.
- req_valid outside IDLE is ignored (req_ready=0).
- Reset mid-operation: every output returns to its reset value immediately. No csr_valid_i is ever emitted for an aborted request.
- csr_valid_i is never high while csr_en is low.

Decomposition:
- Shared package ysyx_22041412_csr_pkg:
  - CSR number constants (MSTATUS=12'h300, MTVEC=12'h305, MEPC=12'h341, MCAUSE=12'h342).
  - Unit index constants (IDX_MRET=0, IDX_ECALL=1, IDX_MSTATUS=2, IDX_MTVEC=3, IDX_MEPC=4, IDX_MCAUSE=5).
  - req_kind enum; rsp_err enum; state enum {IDLE, REQ, ACK, DRAIN, RESP}.
- One combinational sub-module, ysyx_22041412_csr_decode: csr number + kind + func3 → {addr, func3_out, illegal}.

Test Plan:
- CSRRW 0x305 (mtvec), rs1=0x8000_0100; unit model returns old 0x0 → csr_addr=3, csr_wdata=0x8000_0100, one csr_valid_i pulse, rsp_rd_data=0, rsp_err=0, RESP reached exactly 4 cycles after accept.
- CSRRSI 0x300, zimm=8, unit returns 0xa00001800 → csr_wdata=0x8, csr_func3=110, rsp_rd_data=0xa00001800.
- ecall at pc=0x8000_0040, unit returns mtvec 0x8000_0100 → csr_addr=1, csr_func3=000, csr_pc=0x8000_0040, rsp_redirect=1, rsp_redirect_pc=0x8000_0100.
- CSR 0x7C0 (unmapped) → csr_en never asserts, rsp_err=1 one cycle after accept; also func3=100 → rsp_err=1.
- Unit never raises ready, TIMEOUT=16 → csr_en drops after 16 REQ cycles, rsp_err=2, csr_valid_i never asserted.
- rsp_ready held low 5 cycles during mret (mepc=0x8000_0044), then rst pulsed low mid-REQ on the next request → first response stable for the 5 cycles; after reset busy=0, csr_en=0, req_ready=1.
